// File: rtl/pipeline_hazard.sv
// Hazard/forwarding control for the 5-stage pipeline: stall, flush and operand selects are combinational
// from decode inputs plus an EX/MEM/WB writer scoreboard; HAZARD_FWD_EN enables forwarding (else stall-only).
module pipeline_hazard #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [1:0] id_rs_a,
  input  logic [1:0] id_rs_b,
  input  logic       id_use_a,
  input  logic       id_use_b,
  input  logic [1:0] id_ra,
  input  logic       id_reg_en,
  input  logic       id_load,
  input  logic       ex_taken,
  output logic       stall,
  output logic       flush,
  output logic [1:0] fwd_a_sel,
  output logic [1:0] fwd_b_sel
);

  typedef struct packed {
    logic       v;
    logic [1:0] rd;
    logic       load;
  } sb_entry_t;

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  sb_entry_t  sb_ex, sb_mem, sb_wb;
  logic [1:0] cnt;
  logic       hit_ex_a, hit_mem_a, hit_wb_a;
  logic       hit_ex_b, hit_mem_b, hit_wb_b;
  logic       stall_raw;
  logic       sb_load_unused;

  function automatic logic src_hit(input logic rd_use, input logic [1:0] rs, input sb_entry_t e);
    return rd_use & e.v & (e.rd == rs);
  endfunction

  assign hit_ex_a  = id_valid & src_hit(id_use_a, id_rs_a, sb_ex);
  assign hit_mem_a = id_valid & src_hit(id_use_a, id_rs_a, sb_mem);
  assign hit_wb_a  = id_valid & src_hit(id_use_a, id_rs_a, sb_wb);
  assign hit_ex_b  = id_valid & src_hit(id_use_b, id_rs_b, sb_ex);
  assign hit_mem_b = id_valid & src_hit(id_use_b, id_rs_b, sb_mem);
  assign hit_wb_b  = id_valid & src_hit(id_use_b, id_rs_b, sb_wb);

  // The load flag only matters in EX; older copies travel along for visibility.
  assign sb_load_unused = sb_ex.load ^ sb_mem.load ^ sb_wb.load;

  always_comb begin
    flush     = ex_taken | (cnt != 2'd0);
    stall_raw = 1'b0;
    fwd_a_sel = 2'd0;
    fwd_b_sel = 2'd0;
`ifdef HAZARD_FWD_EN
    stall_raw = (hit_ex_a | hit_ex_b) & sb_ex.load;
    if (!flush) begin
      if (hit_ex_a)       fwd_a_sel = 2'd1;
      else if (hit_mem_a) fwd_a_sel = 2'd2;
      else if (hit_wb_a)  fwd_a_sel = 2'd3;
      if (hit_ex_b)       fwd_b_sel = 2'd1;
      else if (hit_mem_b) fwd_b_sel = 2'd2;
      else if (hit_wb_b)  fwd_b_sel = 2'd3;
    end
`else
    stall_raw = hit_ex_a | hit_mem_a | hit_wb_a | hit_ex_b | hit_mem_b | hit_wb_b;
`endif
    stall = stall_raw & ~flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_ex  <= '0;
      sb_mem <= '0;
      sb_wb  <= '0;
      cnt    <= 2'd0;
    end else begin
      sb_wb  <= sb_mem;
      sb_mem <= sb_ex;
      // A held or killed instruction leaves a bubble behind it in EX.
      if (id_valid && id_reg_en && !stall && !flush)
        sb_ex <= '{v: 1'b1, rd: id_ra, load: id_load};
      else
        sb_ex <= '0;
      if (ex_taken)
        cnt <= FLUSH_LOAD;
      else if (cnt != 2'd0)
        cnt <= cnt - 2'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard.sv
// Self-checking bench for pipeline_hazard: directed scenarios then random traffic against an age-based writer model.
module tb_pipeline_hazard;

  localparam int FC = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_a, id_use_b, id_reg_en, id_load, ex_taken;
  logic [1:0] id_rs_a, id_rs_b, id_ra;
  logic       stall, flush;
  logic [1:0] fwd_a_sel, fwd_b_sel;

  always #5 clk = ~clk;

  pipeline_hazard #(.FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs_a(id_rs_a), .id_rs_b(id_rs_b),
    .id_use_a(id_use_a), .id_use_b(id_use_b), .id_ra(id_ra),
    .id_reg_en(id_reg_en), .id_load(id_load), .ex_taken(ex_taken),
    .stall(stall), .flush(flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel)
  );

  // Model: every accepted writer is remembered with the cycle it issued; its age is its stage.
  typedef struct { int issue; logic [1:0] rd; bit load; } wr_t;
  wr_t wq[$];
  int cyc = 0;
  int last_taken = -100;
  int checks = 0;
  int failures = 0;
  int exp_stall, exp_flush, exp_a, exp_b;
  int obs_stall, obs_flush, obs_a, obs_b;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int youngest(input logic u, input logic [1:0] rs, output bit ld);
    int best;
    best = 0;
    ld = 1'b0;
    if (!(u && id_valid)) return 0;
    foreach (wq[i]) begin
      int age;
      age = cyc - wq[i].issue;
      if (age >= 1 && age <= 3 && wq[i].rd == rs && (best == 0 || age < best)) begin
        best = age;
        ld = wq[i].load;
      end
    end
    return best;
  endfunction

  task automatic model_eval();
    bit la, lb;
    int aa, ab;
    exp_flush = (ex_taken || (cyc - last_taken) < FC) ? 1 : 0;
    aa = youngest(id_use_a, id_rs_a, la);
    ab = youngest(id_use_b, id_rs_b, lb);
`ifdef HAZARD_FWD_EN
    exp_stall = (exp_flush == 0 && ((aa == 1 && la) || (ab == 1 && lb))) ? 1 : 0;
    exp_a = (exp_flush != 0) ? 0 : aa;
    exp_b = (exp_flush != 0) ? 0 : ab;
`else
    exp_stall = (exp_flush == 0 && (aa != 0 || ab != 0)) ? 1 : 0;
    exp_a = 0;
    exp_b = 0;
`endif
  endtask

  task automatic model_edge();
    if (id_valid && id_reg_en && exp_stall == 0 && exp_flush == 0)
      wq.push_back('{issue: cyc, rd: id_ra, load: id_load});
    if (ex_taken) last_taken = cyc;
    cyc++;
    while (wq.size() > 0 && cyc - wq[0].issue > 3) void'(wq.pop_front());
  endtask

  task automatic model_reset();
    wq.delete();
    last_taken = -100;
  endtask

  task automatic drive(input logic v, input logic [1:0] ra_s, input logic ua, input logic [1:0] rb_s,
                       input logic ub, input logic [1:0] rd, input logic we, input logic ld, input logic tk);
    id_valid = v; id_rs_a = ra_s; id_use_a = ua; id_rs_b = rb_s; id_use_b = ub;
    id_ra = rd; id_reg_en = we; id_load = ld; ex_taken = tk;
  endtask

  task automatic sample_and_check(input string tag);
    obs_stall = int'(stall); obs_flush = int'(flush);
    obs_a = int'(fwd_a_sel); obs_b = int'(fwd_b_sel);
    model_eval();
    chk({tag, "_stall"}, obs_stall, exp_stall);
    chk({tag, "_flush"}, obs_flush, exp_flush);
    chk({tag, "_fwd_a"}, obs_a, exp_a);
    chk({tag, "_fwd_b"}, obs_b, exp_b);
  endtask

  // Called at a falling edge: drive, check mid-cycle, advance model at the rising edge.
  task automatic step(input string tag, input logic v, input logic [1:0] ra_s, input logic ua,
                      input logic [1:0] rb_s, input logic ub, input logic [1:0] rd, input logic we,
                      input logic ld, input logic tk);
    drive(v, ra_s, ua, rb_s, ub, rd, we, ld, tk);
    #1;
    sample_and_check(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic nop(input string tag);
    step(tag, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input string tag, input logic [1:0] rd, input logic ld);
    step(tag, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, rd, 1'b1, ld, 1'b0);
  endtask

  // Re-present a reader until it is released; report stall count and final select.
  task automatic read_hold(input string tag, input logic [1:0] rs, input bit port_b,
                           output int nstall, output int sel);
    nstall = 0;
    sel = -1;
    for (int i = 0; i < 8; i++) begin
      step(tag, 1'b1, rs, !port_b, rs, port_b, 2'd0, 1'b0, 1'b0, 1'b0);
      if (obs_stall != 0) nstall++;
      else begin
        sel = port_b ? obs_b : obs_a;
        break;
      end
    end
    chk({tag, "_released"}, obs_stall, 0);
  endtask

  int ns, sel, nf;
  logic       r_v, r_ua, r_ub, r_we, r_ld;
  logic [1:0] r_ra, r_rb, r_rd;

  initial begin
    rst = 1'b1;
    drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("reset_stall", int'(stall), 0);
    chk("reset_flush", int'(flush), 0);
    chk("reset_fwd_a", int'(fwd_a_sel), 0);
    chk("reset_fwd_b", int'(fwd_b_sel), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Dependency distance sweep on port A.
    for (int g = 0; g < 4; g++) begin
      wr("gap_wr", 2'd2, 1'b0);
      repeat (g) nop("gap_nop");
      read_hold("gap_rd", 2'd2, 1'b0, ns, sel);
`ifdef HAZARD_FWD_EN
      chk("gap_nstall", ns, 0);
      chk("gap_sel", sel, (g < 3) ? g + 1 : 0);
`else
      chk("gap_nstall", ns, (g < 3) ? 3 - g : 0);
      chk("gap_sel", sel, 0);
`endif
      repeat (3) nop("drain");
    end

    // Load-use on port B.
    wr("ld_wr", 2'd1, 1'b1);
    read_hold("ld_rd", 2'd1, 1'b1, ns, sel);
`ifdef HAZARD_FWD_EN
    chk("ld_nstall", ns, 1);
    chk("ld_sel", sel, 2);
`else
    chk("ld_nstall", ns, 3);
    chk("ld_sel", sel, 0);
`endif
    repeat (3) nop("drain");

    // Two writers to r3 back to back.
    wr("dbl_wr1", 2'd3, 1'b0);
    wr("dbl_wr2", 2'd3, 1'b0);
    read_hold("dbl_rd", 2'd3, 1'b0, ns, sel);
`ifdef HAZARD_FWD_EN
    chk("dbl_nstall", ns, 0);
    chk("dbl_sel", sel, 1);
`else
    chk("dbl_nstall", ns, 3);
    chk("dbl_sel", sel, 0);
`endif
    repeat (3) nop("drain");

    // Taken branch coinciding with a load-use (or plain dependency) hazard.
    wr("br_ld", 2'd1, 1'b1);
    step("br_take", 1'b1, 2'd0, 1'b0, 2'd1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    chk("br_take_flush", obs_flush, 1);
    chk("br_take_nostall", obs_stall, 0);
    nf = 1;
    for (int i = 0; i < 6; i++) begin
      step("br_after", 1'b1, 2'd0, 1'b0, 2'd1, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0);
      if (obs_flush != 0) nf++;
      else break;
    end
    chk("br_flush_len", nf, FC);
    repeat (3) nop("drain");

    // Asynchronous reset with a dependency pending.
    wr("rst_wr", 2'd2, 1'b0);
    drive(1'b1, 2'd2, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    sample_and_check("rst_pre");
    rst = 1'b1;
    #1;
    chk("rst_mid_stall", int'(stall), 0);
    chk("rst_mid_flush", int'(flush), 0);
    chk("rst_mid_fwd_a", int'(fwd_a_sel), 0);
    chk("rst_mid_fwd_b", int'(fwd_b_sel), 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    step("rst_post", 1'b1, 2'd2, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_post_sel", obs_a, 0);

    // Asynchronous reset during an active flush window.
    step("rstf_take", 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("rstf_pre_flush", int'(flush), 1);
    rst = 1'b1;
    #1;
    chk("rstf_mid_flush", int'(flush), 0);
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Random traffic; a stalled instruction is re-presented unchanged.
    r_v = 0; r_ua = 0; r_ub = 0; r_we = 0; r_ld = 0; r_ra = 0; r_rb = 0; r_rd = 0;
    exp_stall = 0;
    for (int i = 0; i < 400; i++) begin
      if (exp_stall == 0) begin
        r_v  = ($urandom_range(0, 4) != 0);
        r_ra = 2'($urandom_range(0, 3));
        r_rb = 2'($urandom_range(0, 3));
        r_ua = 1'($urandom_range(0, 1));
        r_ub = 1'($urandom_range(0, 1));
        r_rd = 2'($urandom_range(0, 3));
        r_we = ($urandom_range(0, 3) != 0);
        r_ld = ($urandom_range(0, 2) == 0);
      end
      step("rnd", r_v, r_ra, r_ua, r_rb, r_ub, r_rd, r_we, r_ld, ($urandom_range(0, 9) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard.md
# pipeline_hazard

Hazard and forwarding controller for the 8-bit five-stage pipeline. It consumes the decode-stage register reads and the destination and control fields that enter the ID/EX pipeline register, and tracks in-flight writers through EX, MEM and WB in an internal scoreboard. From that state it drives stall, flush and operand-forwarding selects back into fetch, decode and the ID/EX register. It is the control counterpart of the ID/EX register: that register carries decoded fields forward, and this block decides when they advance, hold or become bubbles.

## Interface
Parameters:
- FLUSH_CYCLES, default 2: number of cycles flush stays asserted after a taken branch (legal values 1–3).

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- id_valid  in  1  decode stage holds a real instruction
- id_rs_a, id_rs_b  in  2 each  source register indices
- id_use_a, id_use_b  in  1 each  the source is actually read
- id_ra  in  2  destination register of the decoding instruction
- id_reg_en  in  1  decoding instruction writes the register file (wb_reg_en)
- id_load  in  1  decoding instruction writes memory data back (wb_data_sel = 1)
- ex_taken  in  1  the instruction in EX is a resolved taken branch or brx
- stall  out  1  hold the PC and the IF/ID register; insert a bubble into ID/EX
- flush  out  1  kill IF/ID and ID/EX, which load a bubble
- fwd_a_sel, fwd_b_sel  out  2 each  operand source: 0 = register file, 1 = EX result, 2 = MEM result, 3 = WB data

## Operation
- Scoreboard: three entries (EX, MEM, WB). Each entry holds v, rd[1:0] and load.
- Every clock edge: WB←MEM, MEM←EX. The EX entry is loaded with {1, id_ra, id_load} when id_valid & id_reg_en & !stall & !flush. Otherwise EX gets a bubble (v = 0).
- Match rule: a source matches a stage when id_use_x & id_valid & entry.v & entry.rd == id_rs_x.
- Forwarding priority is EX > MEM > WB. The select is the youngest matching stage, or 0 if no stage matches.
- Load-use: if the EX entry matches and EX.load = 1, stall = 1 for that cycle. Once the load has moved to MEM, forwarding uses select 2.
- Flush counter (2 bits): when ex_taken = 1 it is loaded with FLUSH_CYCLES−1 on the edge; otherwise it decrements toward 0.
- flush = ex_taken | (cnt != 0).
- flush overrides stall: when flush = 1, stall = 0.
- While flush = 1, the fwd selects are 0.
- ex_taken re-asserted during an active flush reloads the counter.
- Register index 0 has no special treatment; it is forwarded like any other register.

## Timing
- Reset values: all scoreboard v = 0, cnt = 0, so stall = 0, flush = 0, fwd_a_sel = fwd_b_sel = 0. Reset asserted mid-operation clears the state immediately (asynchronously), not at the next edge.
- stall, flush and the fwd selects are combinational from current inputs and registered state. They are valid in the same cycle as the decode inputs.
- Load-use stall lasts exactly 1 cycle per load. After that cycle, the same instruction sees the load in MEM and gets select 2.
- A taken branch produces flush for FLUSH_CYCLES consecutive cycles, starting in the cycle where ex_taken = 1.
- Two writers to the same register in EX and MEM: EX wins (select 1).
- A writer that leaves WB stops matching on the next edge, and the operand comes from the register file (select 0).
- Simultaneous stall condition and ex_taken: flush = 1, stall = 0, and a bubble enters EX.

## Configuration
- HAZARD_FWD_EN defined: forwarding behaves as described above.
- HAZARD_FWD_EN undefined:
  - fwd_a_sel and fwd_b_sel are tied to 0.
  - Any match against EX, MEM or WB asserts stall.
  - The dependent instruction waits until the producer has left WB: a 3-cycle stall for a back-to-back dependency.
  - The load bit is unused.
  - Flush behaviour is unchanged.

## Test plan
- Reset: assert rst mid-stream with a loaded scoreboard → stall = 0, flush = 0 and fwd selects = 0 immediately. After release, the first dependent instruction sees select 0.
- Back-to-back ALU: write r2, then the next instruction reads r2 on port A → fwd_a_sel = 1, no stall. With a 1-instruction gap → 2. With a 2-instruction gap → 3. With a 3-instruction gap → 0.
- Load-use: load r1, then an instruction reads r1 on port B → stall = 1 for exactly 1 cycle, then fwd_b_sel = 2, and one bubble is observed in the EX entry.
- Double writer: write r3 twice in succession, then read r3 → select 1 (youngest writer).
- Branch: ex_taken = 1 for one cycle with FLUSH_CYCLES = 2 → flush high for 2 cycles, and stall is suppressed even when a load-use condition is present.
- HAZARD_FWD_EN undefined: write r2, then read r2 → stall for 3 cycles, then release with fwd_a_sel = 0.
